div_result_fixup: RTL and testbench
===================================

Name: div_result_fixup

Overview:
- Downstream stage of the combinational width-parameterised divide/modulo operator block.
- Captures the operator's operands and its unsigned and two's-complement quotient/remainder results.
- Replaces undefined results for divide-by-zero and signed overflow with defined values.
- Presents one selected result per transaction through a 2-entry valid/ready output buffer, and keeps saturating exception counters.

Parameters:
- WIDTH, 8, operand/result width; must match the upstream operator.
- CNT_W, 16, width of each exception counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream transaction valid.
- in_ready  out  1  stage can accept a transaction.
- in_tc  in  1  1 = select two's-complement results, 0 = unsigned.
- in_a  in  WIDTH  dividend presented to the operator.
- in_b  in  WIDTH  divisor presented to the operator.
- in_quotient_uns  in  WIDTH  operator unsigned quotient.
- in_remainder_uns  in  WIDTH  operator unsigned remainder.
- in_quotient_tc  in  WIDTH  operator signed quotient.
- in_remainder_tc  in  WIDTH  operator signed remainder.
- out_valid  out  1  head buffer entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_quotient  out  WIDTH  fixed-up quotient.
- out_remainder  out  WIDTH  fixed-up remainder.
- out_div0  out  1  entry was a divide-by-zero.
- out_ovf  out  1  entry was a signed overflow.
- cnt_clr  in  1  synchronous clear of both counters.
- div0_cnt  out  CNT_W  saturating count of accepted divide-by-zero transactions.
- ovf_cnt  out  CNT_W  saturating count of accepted overflow transactions.

Behaviour:
- Accept rule: a transaction is accepted when in_valid && in_ready.
- in_ready is 1 when the buffer holds fewer than 2 entries. It is combinational from occupancy only, never from out_ready.
- Fixup is computed combinationally from the inputs in the accept cycle and written into the buffer:
  - div0 = (in_b == 0). Result: quotient = all ones, remainder = in_a, in both modes.
  - ovf = in_tc && in_a == {1,0...0} && in_b == all ones. Result: quotient = in_a (most negative value), remainder = 0.
  - Otherwise: the in_tc-selected operator outputs pass through unchanged.
  - When div0 or ovf is set, operator result inputs are ignored; they may be X.
  - ovf is never set in unsigned mode. div0 takes priority (when in_b = 0, ovf cannot also hold).
- Latency: a transaction accepted at edge N appears with out_valid = 1 after edge N, if the buffer was empty.
- The buffer is a strict 2-entry FIFO; output order equals accept order.
- Pop occurs when out_valid && out_ready.
- Simultaneous push and pop with occupancy 1 leaves occupancy 1; the new entry becomes head after the old one leaves.
- With occupancy 0, out_valid = 0 and out_* data holds its last value (don't-care for checking).
- No push is possible when full, since in_ready = 0; a pop in that cycle frees one slot for the next cycle.
- Counters increment by 1 on an accepted div0 or ovf transaction, at the accept edge, and saturate at all ones.
- cnt_clr wins over a same-cycle increment: both counters become 0.
- Reset (rst = 1 at an edge, including mid-stream):
  - buffer emptied: out_valid = 0, in_ready = 1.
  - out_quotient, out_remainder, out_div0, out_ovf = 0.
  - div0_cnt, ovf_cnt = 0.
  - in-flight entries are discarded; rst overrides any accept or pop in that cycle.
- No other state; throughput is 1 transaction per cycle while out_ready = 1.

Test Plan:
1. Unsigned, WIDTH 8: a = 200, b = 7, operator q = 28, r = 4, out_ready = 1 -> next cycle out_valid = 1, q = 0x1C, r = 0x04, flags 0, counters unchanged.
2. Signed: a = 0xF9 (−7), b = 0x02, operator q = 0xFD, r = 0xFF -> output q = 0xFD, r = 0xFF, flags 0. Then a = 0x80, b = 0xFF, operator results X -> q = 0x80, r = 0x00, out_ovf = 1, ovf_cnt = 1. The same operands with in_tc = 0 -> operator results pass through, ovf = 0.
3. Divide-by-zero: a = 0x55, b = 0, both modes, operator results X -> q = 0xFF, r = 0x55, out_div0 = 1; div0_cnt = 2 after both.
4. Backpressure: out_ready = 0, offer 3 back-to-back transactions -> in_ready drops after 2 accepts and the third is held. Raise out_ready -> outputs appear in order with no loss or duplication. Also check a simultaneous push/pop at occupancy 1.
5. Counter saturation/clear, CNT_W = 4: 17 div0 transactions -> div0_cnt = 15. Assert cnt_clr in the same cycle as a div0 accept -> div0_cnt = 0.
6. Reset mid-stream: buffer full, counters nonzero, pulse rst for 1 cycle -> next cycle out_valid = 0, in_ready = 1, all outputs and counters 0; a subsequent transaction is processed normally.

Source files
------------

// File: rtl/div_result_fixup.sv
// div_result_fixup: result fix-up stage behind the combinational divide/modulo
// operator. It replaces divide-by-zero and signed-overflow results with defined
// values and sends one result per transaction through a 2-entry in-order
// valid/ready buffer. It also keeps two saturating exception counters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready depends only on occupancy)
//   in_tc                    1 = two's-complement results, 0 = unsigned
//   in_a, in_b               operands seen by the operator
//   in_quotient_*/in_remainder_*  operator results (unsigned and signed)
//   out_valid/out_ready      downstream handshake for the head entry
//   out_quotient/out_remainder/out_div0/out_ovf  head entry payload
//   cnt_clr                  synchronous clear of both counters
//   div0_cnt, ovf_cnt        saturating exception counters
module div_result_fixup #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_tc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_quotient_uns,
  input  logic [WIDTH-1:0] in_remainder_uns,
  input  logic [WIDTH-1:0] in_quotient_tc,
  input  logic [WIDTH-1:0] in_remainder_tc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div0,
  output logic             out_ovf,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] div0_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // The head entry is held directly in the out_* registers. The tail entry is
  // used only while the buffer holds two entries.
  logic [1:0]       occ, occ_nxt;
  logic [WIDTH-1:0] tail_q, tail_q_nxt, tail_r, tail_r_nxt;
  logic             tail_div0, tail_div0_nxt, tail_ovf, tail_ovf_nxt;
  logic [WIDTH-1:0] head_q_nxt, head_r_nxt;
  logic             head_div0_nxt, head_ovf_nxt;
  logic [CNT_W-1:0] div0_cnt_nxt, ovf_cnt_nxt;

  logic             push_c, pop_c;
  logic             fix_div0_c, fix_ovf_c;
  logic [WIDTH-1:0] fix_q_c, fix_r_c;

  assign push_c = in_valid && in_ready;
  assign pop_c  = out_valid && out_ready;

  // Fix-up of the incoming operator results. div0 has priority, although it
  // cannot coincide with ovf because ovf requires in_b to be all ones.
  always_comb begin
    fix_div0_c = (in_b == '0);
    fix_ovf_c  = in_tc && (in_a == MOST_NEG) && (in_b == ALL_ONES);
    fix_q_c    = in_tc ? in_quotient_tc  : in_quotient_uns;
    fix_r_c    = in_tc ? in_remainder_tc : in_remainder_uns;
    if (fix_div0_c) begin
      fix_q_c = ALL_ONES;
      fix_r_c = in_a;
    end else if (fix_ovf_c) begin
      fix_q_c = in_a;
      fix_r_c = '0;
    end
  end

  // Next-state logic for buffer occupancy, head/tail entries and counters.
  always_comb begin
    occ_nxt       = occ;
    head_q_nxt    = out_quotient;
    head_r_nxt    = out_remainder;
    head_div0_nxt = out_div0;
    head_ovf_nxt  = out_ovf;
    tail_q_nxt    = tail_q;
    tail_r_nxt    = tail_r;
    tail_div0_nxt = tail_div0;
    tail_ovf_nxt  = tail_ovf;
    div0_cnt_nxt  = div0_cnt;
    ovf_cnt_nxt   = ovf_cnt;

    if (push_c && !pop_c) begin
      if (occ == 2'd0) begin
        head_q_nxt    = fix_q_c;
        head_r_nxt    = fix_r_c;
        head_div0_nxt = fix_div0_c;
        head_ovf_nxt  = fix_ovf_c;
      end else begin
        tail_q_nxt    = fix_q_c;
        tail_r_nxt    = fix_r_c;
        tail_div0_nxt = fix_div0_c;
        tail_ovf_nxt  = fix_ovf_c;
      end
      occ_nxt = occ + 2'd1;
    end else if (pop_c && !push_c) begin
      if (occ == 2'd2) begin
        head_q_nxt    = tail_q;
        head_r_nxt    = tail_r;
        head_div0_nxt = tail_div0;
        head_ovf_nxt  = tail_ovf;
      end
      occ_nxt = occ - 2'd1;
    end else if (push_c && pop_c) begin
      // Push and pop together are only possible with one entry, so the new
      // entry replaces the departing head.
      head_q_nxt    = fix_q_c;
      head_r_nxt    = fix_r_c;
      head_div0_nxt = fix_div0_c;
      head_ovf_nxt  = fix_ovf_c;
    end

    if (cnt_clr) begin
      div0_cnt_nxt = '0;
      ovf_cnt_nxt  = '0;
    end else begin
      if (push_c && fix_div0_c && (div0_cnt != CNT_MAX)) div0_cnt_nxt = div0_cnt + CNT_W'(1);
      if (push_c && fix_ovf_c  && (ovf_cnt  != CNT_MAX)) ovf_cnt_nxt  = ovf_cnt  + CNT_W'(1);
    end
  end

  // State registers. in_ready and out_valid are registered copies of the next
  // occupancy, so in_ready depends on occupancy alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ           <= 2'd0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div0      <= 1'b0;
      out_ovf       <= 1'b0;
      tail_q        <= '0;
      tail_r        <= '0;
      tail_div0     <= 1'b0;
      tail_ovf      <= 1'b0;
      div0_cnt      <= '0;
      ovf_cnt       <= '0;
    end else begin
      occ           <= occ_nxt;
      in_ready      <= (occ_nxt != 2'd2);
      out_valid     <= (occ_nxt != 2'd0);
      out_quotient  <= head_q_nxt;
      out_remainder <= head_r_nxt;
      out_div0      <= head_div0_nxt;
      out_ovf       <= head_ovf_nxt;
      tail_q        <= tail_q_nxt;
      tail_r        <= tail_r_nxt;
      tail_div0     <= tail_div0_nxt;
      tail_ovf      <= tail_ovf_nxt;
      div0_cnt      <= div0_cnt_nxt;
      ovf_cnt       <= ovf_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_div_result_fixup.sv
// Directed bench for div_result_fixup (WIDTH 8, CNT_W 4) with hand-computed expectations.
module tb_div_result_fixup;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_tc;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] in_quotient_uns, in_remainder_uns;
  logic [WIDTH-1:0] in_quotient_tc, in_remainder_tc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient, out_remainder;
  logic             out_div0, out_ovf;
  logic             cnt_clr;
  logic [CNT_W-1:0] div0_cnt, ovf_cnt;

  int tests  = 0;
  int failed = 0;

  div_result_fixup #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_tc            (in_tc),
    .in_a             (in_a),
    .in_b             (in_b),
    .in_quotient_uns  (in_quotient_uns),
    .in_remainder_uns (in_remainder_uns),
    .in_quotient_tc   (in_quotient_tc),
    .in_remainder_tc  (in_remainder_tc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_quotient     (out_quotient),
    .out_remainder    (out_remainder),
    .out_div0         (out_div0),
    .out_ovf          (out_ovf),
    .cnt_clr          (cnt_clr),
    .div0_cnt         (div0_cnt),
    .ovf_cnt          (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic tc, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] qu, input logic [7:0] ru,
                       input logic [7:0] qt, input logic [7:0] rt);
    in_valid         = v;
    in_tc            = tc;
    in_a             = a;
    in_b             = b;
    in_quotient_uns  = qu;
    in_remainder_uns = ru;
    in_quotient_tc   = qt;
    in_remainder_tc  = rt;
  endtask

  task automatic check_head(input string tag, input logic [7:0] q, input logic [7:0] r,
                            input logic d0, input logic ov);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " q"},     32'(out_quotient), 32'(q));
    check({tag, " r"},     32'(out_remainder), 32'(r));
    check({tag, " div0"},  32'(out_div0), 32'(d0));
    check({tag, " ovf"},   32'(out_ovf), 32'(ov));
  endtask

  initial begin
    rst = 1'b1; cnt_clr = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    check("reset valid",    32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset q",        32'(out_quotient), 32'd0);
    check("reset div0_cnt", 32'(div0_cnt), 32'd0);
    check("reset ovf_cnt",  32'(ovf_cnt), 32'd0);

    // Unsigned pass-through: 200 / 7 = 28 r 4; the signed inputs must be ignored.
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 8'hAA, 8'hBB);
    tick();
    check_head("uns", 8'h1C, 8'h04, 1'b0, 1'b0);
    check("uns div0_cnt", 32'(div0_cnt), 32'd0);

    // Signed pass-through: -7 / 2 = -3 r -1.
    drive(1'b1, 1'b1, 8'hF9, 8'h02, 8'h11, 8'h22, 8'hFD, 8'hFF);
    tick();
    check_head("tc", 8'hFD, 8'hFF, 1'b0, 1'b0);

    // Signed overflow: -128 / -1.
    drive(1'b1, 1'b1, 8'h80, 8'hFF, 8'hxx, 8'hxx, 8'hxx, 8'hxx);
    tick();
    check_head("ovf", 8'h80, 8'h00, 1'b0, 1'b1);
    check("ovf ovf_cnt", 32'(ovf_cnt), 32'd1);

    // Same operands unsigned: 128 / 255 = 0 r 128 and no overflow.
    drive(1'b1, 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 8'h5A, 8'hA5);
    tick();
    check_head("uns80", 8'h00, 8'h80, 1'b0, 1'b0);
    check("uns80 ovf_cnt", 32'(ovf_cnt), 32'd1);

    // Divide-by-zero in both modes.
    drive(1'b1, 1'b0, 8'h55, 8'h00, 8'hxx, 8'hxx, 8'hxx, 8'hxx);
    tick();
    check_head("div0 uns", 8'hFF, 8'h55, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 8'h55, 8'h00, 8'hxx, 8'hxx, 8'hxx, 8'hxx);
    tick();
    check_head("div0 tc", 8'hFF, 8'h55, 1'b1, 1'b0);
    check("div0 div0_cnt", 32'(div0_cnt), 32'd2);
    in_valid = 1'b0;
    tick();
    check("drain valid", 32'(out_valid), 32'd0);

    // Backpressure: A = 10/3, B = 50/6, C = 30/4 (unsigned).
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'd10, 8'd3, 8'd3, 8'd1, 8'h00, 8'h00);
    tick();
    check_head("bp A", 8'd3, 8'd1, 1'b0, 1'b0);
    check("bp in_ready 1", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b0, 8'd50, 8'd6, 8'd8, 8'd2, 8'h00, 8'h00);
    tick();
    check("bp in_ready full", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b0, 8'd30, 8'd4, 8'd7, 8'd2, 8'h00, 8'h00);
    tick();
    check("bp held in_ready", 32'(in_ready), 32'd0);
    check_head("bp held A", 8'd3, 8'd1, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check_head("bp B", 8'd8, 8'd2, 1'b0, 1'b0);
    check("bp in_ready freed", 32'(in_ready), 32'd1);
    tick();
    check_head("bp C", 8'd7, 8'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    check("bp drained", 32'(out_valid), 32'd0);

    // Clear, then saturate div0_cnt at 15 with 17 div0 transactions.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr div0_cnt", 32'(div0_cnt), 32'd0);
    check("clr ovf_cnt",  32'(ovf_cnt), 32'd0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 8'(i), 8'h00, 8'hxx, 8'hxx, 8'hxx, 8'hxx);
      tick();
      if (i == 13) check("sat 14", 32'(div0_cnt), 32'd14);
    end
    check("sat div0_cnt", 32'(div0_cnt), 32'd15);
    check_head("sat last", 8'hFF, 8'd16, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr wins", 32'(div0_cnt), 32'd0);
    in_valid = 1'b0;
    tick();

    // Reset mid-stream with a full buffer and nonzero counters.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h12, 8'h00, 8'hxx, 8'hxx, 8'hxx, 8'hxx);
    tick();
    drive(1'b1, 1'b1, 8'h80, 8'hFF, 8'hxx, 8'hxx, 8'hxx, 8'hxx);
    tick();
    in_valid = 1'b0;
    check("pre-rst in_ready", 32'(in_ready), 32'd0);
    check("pre-rst div0_cnt", 32'(div0_cnt), 32'd1);
    check("pre-rst ovf_cnt",  32'(ovf_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst valid",    32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst q",        32'(out_quotient), 32'd0);
    check("rst r",        32'(out_remainder), 32'd0);
    check("rst div0",     32'(out_div0), 32'd0);
    check("rst ovf",      32'(out_ovf), 32'd0);
    check("rst div0_cnt", 32'(div0_cnt), 32'd0);
    check("rst ovf_cnt",  32'(ovf_cnt), 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 8'd100, 8'd9, 8'd11, 8'd1, 8'h00, 8'h00);
    tick();
    in_valid = 1'b0;
    check_head("post-rst", 8'h0B, 8'h01, 1'b0, 1'b0);
    tick();
    check("post-rst drained", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
